eth_rx_frontend: RTL



---
 rtl/eth_rx_frontend.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frontend.sv
// eth_rx_frontend: PHY receive front end.
// Accepts GMII bytes (eth_mode=1) or MII nibbles (eth_mode=0), strips preamble
// and SFD, assembles nibbles into bytes and emits a byte stream with sof/eof/err
// markers. Each byte is held for one byte-time so the final byte can carry eof.
// Optional frame statistics are built only when ETH_RX_STATS_EN is defined;
// otherwise stat_ok/stat_err are tied to zero.
module eth_rx_frontend (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        eth_mode,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        mode_reg, mode_next;          // 1 = byte lanes, latched at frame start
    logic        seen5_reg, seen5_next;        // a 0x5 nibble has been seen in preamble
    logic        phase_reg, phase_next;        // 0 = expecting low nibble
    logic [3:0]  nib_low_reg, nib_low_next;
    logic [7:0]  hold_reg, hold_next;
    logic        hold_valid_reg, hold_valid_next;
    logic        first_reg, first_next;        // next emitted byte starts the frame
    logic        err_reg, err_next;            // sticky frame error
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        sof_reg, sof_next;
    logic        eof_reg, eof_next;
    logic        oerr_reg, oerr_next;
`ifdef ETH_RX_STATS_EN
    logic        zero_len_reg, zero_len_next;  // DATA exited without any byte
`endif

    // Preamble checks use the live eth_mode on the IDLE->PRE cycle, the latched one afterwards
    logic        pre_mode;
    logic        pre_seen;
    logic [7:0]  asm_byte;
    logic        asm_done;

    assign pre_mode = (state_reg == ST_IDLE) ? eth_mode : mode_reg;
    assign pre_seen = (state_reg == ST_IDLE) ? 1'b0 : seen5_reg;

    // State and datapath registers
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state_reg      <= ST_DROP;
            mode_reg       <= 1'b1;
            seen5_reg      <= 1'b0;
            phase_reg      <= 1'b0;
            nib_low_reg    <= 4'h0;
            hold_reg       <= 8'h00;
            hold_valid_reg <= 1'b0;
            first_reg      <= 1'b1;
            err_reg        <= 1'b0;
            data_reg       <= 8'h00;
            valid_reg      <= 1'b0;
            sof_reg        <= 1'b0;
            eof_reg        <= 1'b0;
            oerr_reg       <= 1'b0;
`ifdef ETH_RX_STATS_EN
            zero_len_reg   <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            mode_reg       <= mode_next;
            seen5_reg      <= seen5_next;
            phase_reg      <= phase_next;
            nib_low_reg    <= nib_low_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            first_reg      <= first_next;
            err_reg        <= err_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            sof_reg        <= sof_next;
            eof_reg        <= eof_next;
            oerr_reg       <= oerr_next;
`ifdef ETH_RX_STATS_EN
            zero_len_reg   <= zero_len_next;
`endif
        end
    end

    // Next-state, byte assembly and output generation
    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        seen5_next      = seen5_reg;
        phase_next      = phase_reg;
        nib_low_next    = nib_low_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        first_next      = first_reg;
        err_next        = err_reg;
        data_next       = data_reg;
        valid_next      = 1'b0;
        sof_next        = 1'b0;
        eof_next        = 1'b0;
        oerr_next       = 1'b0;
        asm_byte        = 8'h00;
        asm_done        = 1'b0;
`ifdef ETH_RX_STATS_EN
        zero_len_next   = 1'b0;
`endif

        case (state_reg)
            ST_IDLE, ST_PRE: begin
                if (state_reg == ST_IDLE) begin
                    seen5_next = 1'b0;
                end
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                end else begin
                    if (state_reg == ST_IDLE) begin
                        mode_next = eth_mode;
                    end
                    if (rx_er) begin
                        state_next = ST_DROP;
                    end else if (pre_mode) begin
                        if (rxd == 8'h55) begin
                            state_next = ST_PRE;
                        end else if (rxd == 8'hD5) begin
                            state_next = ST_DATA;
                        end else begin
                            state_next = ST_DROP;
                        end
                    end else begin
                        if (rxd[3:0] == 4'h5) begin
                            state_next = ST_PRE;
                            seen5_next = 1'b1;
                        end else if (rxd[3:0] == 4'hD && pre_seen) begin
                            state_next = ST_DATA;
                        end else begin
                            state_next = ST_DROP;
                        end
                    end
                    // Fresh frame context whenever payload is about to start
                    if (state_next == ST_DATA) begin
                        phase_next      = 1'b0;
                        hold_valid_next = 1'b0;
                        first_next      = 1'b1;
                        err_next        = 1'b0;
                    end
                end
            end

            ST_DATA: begin
                if (rx_dv) begin
                    err_next = err_reg | rx_er;
                    if (mode_reg) begin
                        asm_byte = rxd;
                        asm_done = 1'b1;
                    end else if (!phase_reg) begin
                        nib_low_next = rxd[3:0];
                        phase_next   = 1'b1;
                    end else begin
                        asm_byte   = {rxd[3:0], nib_low_reg};
                        asm_done   = 1'b1;
                        phase_next = 1'b0;
                    end
                    // A newly completed byte pushes the held one out (not last)
                    if (asm_done) begin
                        hold_next       = asm_byte;
                        hold_valid_next = 1'b1;
                        if (hold_valid_reg) begin
                            data_next  = hold_reg;
                            valid_next = 1'b1;
                            sof_next   = first_reg;
                            first_next = 1'b0;
                        end
                    end
                end else begin
                    // End of frame: flush the held byte as the last one
                    state_next = ST_IDLE;
                    if (hold_valid_reg) begin
                        data_next  = hold_reg;
                        valid_next = 1'b1;
                        sof_next   = first_reg;
                        eof_next   = 1'b1;
                        oerr_next  = err_reg | (!mode_reg & phase_reg);
                    end else begin
`ifdef ETH_RX_STATS_EN
                        zero_len_next = 1'b1;
`endif
                    end
                    hold_valid_next = 1'b0;
                    err_next        = 1'b0;
                    phase_next      = 1'b0;
                    first_next      = 1'b1;
                end
            end

            default: begin
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign out_sof   = sof_reg;
    assign out_eof   = eof_reg;
    assign out_err   = oerr_reg;

`ifdef ETH_RX_STATS_EN
    // Index 0 counts good frames, index 1 counts bad and zero-length frames
    logic [1:0] stat_inc;
    assign stat_inc[0] = valid_reg & eof_reg & ~oerr_reg;
    assign stat_inc[1] = (valid_reg & eof_reg & oerr_reg) | zero_len_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        // Saturating frame counter, cleared only by reset
        always_ff @(posedge rx_clk) begin
            if (reset) begin
                cnt_reg <= 16'h0000;
            end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign stat_ok  = g_stat[0].cnt_reg;
    assign stat_err = g_stat[1].cnt_reg;
`else
    assign stat_ok  = 16'h0000;
    assign stat_err = 16'h0000;
`endif

endmodule
